seq_det_param: RTL and testbench

Parametrised Moore-style serial pattern detector. It is the next generation of the fixed 4-bit "1101" detector: runtime-programmable pattern and length, a valid qualifier on the input, overlapping or non-overlapping match mode, and a saturating hit counter. It sits on a serial bit stream, e.g. a deserialiser front end or a frame-sync search, and flags each completed pattern.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_param_sat_counter.sv | 36 +++
 rtl/seq_det_param.sv | 128 ++++++++++++
 tb/tb_seq_det_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Defaults reproduce the legacy fixed "1101" detector.
package seq_det_pkg;

    localparam int         DEF_MAX_LEN = 8;
    localparam int         DEF_CNT_W   = 16;
    localparam logic [7:0] DEF_PAT     = 8'b0000_1101;
    localparam int         DEF_LEN     = 4;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Bits needed to hold a length in the range 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == '1);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with a valid qualifier,
// overlap / non-overlap matching and a saturating hit counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = DEF_MAX_LEN,
    parameter int                 CNT_W   = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PAT),
    parameter int                 RST_LEN = DEF_LEN,
    parameter bit                 RST_OVL = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           din_vld,
    input  logic                           din,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pat,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_ovl,
    input  logic                           clr,
    output logic                           hit,
    output logic [CNT_W-1:0]               hit_cnt
);

    localparam int                LEN_W     = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
    localparam ovl_mode_e         RST_OVL_C = RST_OVL ? OVL_ON : OVL_OFF;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               fresh_q, fresh_d;
    logic               hit_q, hit_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    ovl_mode_e          ovl_q, ovl_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               match;
    logic               cnt_inc;
    logic               cnt_sat;

    // Bits at or above the programmed length never take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    assign match = fresh_q
                && (len_q != '0)
                && (fill_q >= len_q)
                && (((hist_q ^ pat_q) & len_mask) == '0);

    assign fill_inc        = (fill_q == MAX_LEN_C) ? fill_q : fill_q + LEN_W'(1);
    assign cfg_len_clamped = (cfg_len > MAX_LEN_C) ? MAX_LEN_C : cfg_len;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        fresh_d = 1'b0;
        hit_d   = 1'b0;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;

        if (cfg_load) begin
            // New configuration: restart the search and drop this edge's bit.
            pat_d  = cfg_pat;
            len_d  = cfg_len_clamped;
            ovl_d  = cfg_ovl ? OVL_ON : OVL_OFF;
            fill_d = '0;
        end else begin
            hit_d = match;
            if (din_vld) begin
                hist_d  = {hist_q[MAX_LEN-2:0], din};
                fill_d  = fill_inc;
                fresh_d = 1'b1;
            end
            // Non-overlap: the matched bits are consumed, only a bit arriving
            // on the match edge counts toward the next pattern.
            if (match && (ovl_q == OVL_OFF)) begin
                fill_d = din_vld ? LEN_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            fresh_q <= 1'b0;
            hit_q   <= 1'b0;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN_C;
            ovl_q   <= RST_OVL_C;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            fresh_q <= fresh_d;
            hit_q   <= hit_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
        end
    end

    assign cnt_inc = match && !cfg_load;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (cnt_inc),
        .clr_i (clr),
        .cnt_o (hit_cnt),
        .sat_o (cnt_sat)
    );

    assign hit = hit_q;

    logic unused_ok;
    assign unused_ok = cnt_sat;

endmodule

// File: tb/tb_seq_det_param.sv
// Randomised and directed bench for seq_det_param against a bit-list model.
module tb_seq_det_param;

    localparam int MAXL    = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           din_vld = 1'b0;
    logic           din = 1'b0;
    logic           cfg_load = 1'b0;
    logic [MAXL-1:0] cfg_pat = '0;
    logic [3:0]     cfg_len = '0;
    logic           cfg_ovl = 1'b0;
    logic           clr = 1'b0;
    logic           hit;
    logic [CW-1:0]  hit_cnt;

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";

    // Model: the bits received since the last restart, newest at the back.
    bit        m_q[$];
    bit [7:0]  m_pat;
    int        m_len;
    bit        m_ovl;
    bit        m_pend;
    bit        m_hit;
    int        m_cnt;

    seq_det_param #(
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_vld  (din_vld),
        .din      (din),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
        .clr      (clr),
        .hit      (hit),
        .hit_cnt  (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d want %0d at t=%0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pat  = 8'b0000_1101;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_pend = 1'b0;
        m_hit  = 1'b0;
        m_cnt  = 0;
    endfunction

    function automatic bit model_match();
        if (!m_pend || m_len == 0 || m_q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_edge();
        bit mm;
        mm = model_match();
        if (cfg_load) begin
            m_pat  = cfg_pat;
            m_len  = (int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len);
            m_ovl  = cfg_ovl;
            m_q.delete();
            m_pend = 1'b0;
            m_hit  = 1'b0;
        end else begin
            m_hit = mm;
            if (mm && !m_ovl) m_q.delete();
            if (din_vld) begin
                m_q.push_back(din);
                if (m_q.size() > MAXL) void'(m_q.pop_front());
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end
        if (clr) m_cnt = 0;
        else if (mm && !cfg_load && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    task automatic cyc(input bit vld, input bit d, input bit ld, input bit c);
        @(negedge clk);
        din_vld  = vld;
        din      = d;
        cfg_load = ld;
        clr      = c;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        chk("hit", 32'(hit), 32'(m_hit));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        $display("[%s] t=%0t vld=%0b din=%0b ld=%0b clr=%0b -> hit=%0b cnt=%0d",
                 phase, $time, vld, d, ld, c, hit, hit_cnt);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cfg_pat = p;
        cfg_len = l;
        cfg_ovl = o;
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, b[i], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();

        phase = "reset";
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "default";
        send(16'b1101, 4);
        chk("no_early_hit", 32'(hit), 0);
        idle(1);
        chk("hit_after_2", 32'(hit), 1);
        idle(2);
        chk("dflt_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "ovl_on";
        load(8'b1101, 4'd4, 1'b1);
        send(16'b1101101, 7);
        idle(2);
        chk("ovl_cnt", 32'(hit_cnt), 2);
        clear_cnt();

        phase = "ovl_off";
        load(8'b1101, 4'd4, 1'b0);
        send(16'b1101101, 7);
        idle(2);
        chk("novl_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "gaps";
        load(8'b1101, 4'd4, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("gap_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "len8";
        load(8'hA5, 4'd8, 1'b1);
        send(16'b1010_0101, 8);
        idle(2);
        chk("len8_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "len0";
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 24; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(2);
        chk("len0_cnt", 32'(hit_cnt), 0);

        phase = "len12";
        load(8'hA5, 4'd12, 1'b1);
        send(16'b1010_0101, 8);
        idle(2);
        chk("clamp_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "load_on_match";
        load(8'b1101, 4'd4, 1'b1);
        send(16'b1101, 4);
        load(8'b1101, 4'd4, 1'b1);
        chk("ld_suppress", 32'(hit), 0);
        send(16'b101, 3);
        idle(2);
        chk("fill_restart", 32'(hit_cnt), 0);
        send(16'b1101, 4);
        idle(2);
        chk("after_ld_cnt", 32'(hit_cnt), 1);
        clear_cnt();

        phase = "saturate";
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("sat_cnt", 32'(hit_cnt), 15);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_hit", 32'(hit), 1);
        chk("clr_cnt", 32'(hit_cnt), 0);

        phase = "async_rst";
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        send(16'b110, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_hit", 32'(hit), 0);
        chk("rst_cnt", 32'(hit_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("lost_partial", 32'(hit_cnt), 0);
        send(16'b1101, 4);
        idle(2);
        chk("post_rst_cnt", 32'(hit_cnt), 1);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                load(8'($urandom), 4'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15)
                                                                : $urandom_range(1, 4)),
                     1'($urandom_range(0, 1)));
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                    1'($urandom_range(0, 49) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
